// File: rtl/lut_eval_scheduler.sv
// ============================================================================
// Module   : lut_eval_scheduler
// Brief    : Replays a buffered set of input vectors through a combinational
//            LUT datapath, waits for it to settle, and streams each result out
//            on a valid/ready port tagged with its buffer index.
//            Optional running checksum output: LUT_SCHED_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module lut_eval_scheduler #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 20,
    parameter int AW     = 5,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lut_inp,
    input  logic [WIDTH-1:0] lut_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
`ifdef LUT_SCHED_CHECKSUM_EN
    output logic [15:0]      checksum,
`endif
    output logic [AW-1:0]    res_index
);

    localparam int            CW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] C_CNT_LAST  = CW'(SETTLE - 1);
    localparam logic [AW-1:0] C_IDX_LAST  = AW'(DEPTH - 1);
    localparam logic [AW:0]   C_DEPTH     = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_OUTPUT = 2'd2,
        S_FIN    = 2'd3
    } state_t;

    state_t           state_q,     state_d;
    logic [AW-1:0]    idx_q,       idx_d;
    logic [CW-1:0]    cnt_q,       cnt_d;
    logic [WIDTH-1:0] lut_inp_q,   lut_inp_d;
    logic             busy_q,      busy_d;
    logic             done_q,      done_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_data_q,  res_data_d;
    logic [AW-1:0]    res_index_q, res_index_d;
    logic [15:0]      csum_q,      csum_d;

    logic [WIDTH-1:0] vec_mem [DEPTH];
    logic [AW-1:0]    w_idx_next;

    assign w_idx_next = idx_q + AW'(1);

    // Buffer has no reset so its contents survive an aborted run.
    always_ff @(posedge clk) begin
        if (wr_en && !busy_q && ({1'b0, wr_addr} < C_DEPTH)) begin
            vec_mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        lut_inp_d   = lut_inp_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_index_d = res_index_q;
        csum_d      = csum_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d     = '0;
                    cnt_d     = '0;
                    lut_inp_d = vec_mem[0];
                    busy_d    = 1'b1;
                    csum_d    = '0;
                    state_d   = S_DRIVE;
                end
            end
            S_DRIVE: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == C_CNT_LAST) begin
                    res_data_d  = lut_out;
                    res_index_d = idx_q;
                    res_valid_d = 1'b1;
                    state_d     = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    csum_d      = csum_q + 16'(res_data_q);
                    if (idx_q == C_IDX_LAST) begin
                        state_d = S_FIN;
                    end else begin
                        idx_d     = w_idx_next;
                        lut_inp_d = vec_mem[w_idx_next];
                        cnt_d     = '0;
                        state_d   = S_DRIVE;
                    end
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            lut_inp_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_index_q <= '0;
            csum_q      <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            lut_inp_q   <= lut_inp_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_index_q <= res_index_d;
            csum_q      <= csum_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign lut_inp   = lut_inp_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_index = res_index_q;

`ifdef LUT_SCHED_CHECKSUM_EN
    assign checksum = csum_q;
`else
    logic w_csum_unused;
    assign w_csum_unused = ^csum_q;
`endif

endmodule

`default_nettype wire
